// File: rtl/dram_seq_pkg.sv
// Shared types and constants for the DRAM command sequencer and its done-path synchroniser.
package dram_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RESP
   } state_e;

   localparam logic [1:0] MODEL_IDLE = 2'b00;
   localparam logic [1:0] MODEL_WR   = 2'b01;
   localparam logic [1:0] MODEL_RD   = 2'b10;

   localparam logic OP_WR = 1'b0;
   localparam logic OP_RD = 1'b1;

   localparam int DATA_W  = 64;
   localparam int RDATA_W = 8;

   function automatic logic [1:0] model_of(input logic op);
      return (op == OP_RD) ? MODEL_RD : MODEL_WR;
   endfunction

endpackage

// File: rtl/dram_done_sync.sv
// Two-flop synchroniser for an asynchronous done level, followed by a rising-edge detector.
module dram_done_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[0], async_in};
      prev_d = sync_q[1];
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/dram_cmd_sequencer.sv
// Host command stage for the 16-core DRAM write/read top; one operation outstanding at a time.
// Optional WAIT_DONE abort timer is built when DRAM_SEQ_TIMEOUT_EN is defined.
module dram_cmd_sequencer
   import dram_seq_pkg::*;
#(
   parameter int NUM_CORE       = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_op,
   input  logic [5:0]                    cmd_wt_addr,
   input  logic [7:0]                    cmd_rd_addr,
   input  logic [DATA_W*NUM_CORE-1:0]    cmd_wt_data,
   output logic                          io_en,
   output logic [1:0]                    io_model,
   output logic [DATA_W*NUM_CORE-1:0]    wt_data,
   output logic [5:0]                    wt_address,
   output logic [7:0]                    rd_address,
   input  logic                          wt_done,
   input  logic                          rd_done,
   input  logic [RDATA_W*NUM_CORE-1:0]   dram_rd_data,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          rsp_op,
   output logic [RDATA_W*NUM_CORE-1:0]   rsp_data,
   output logic                          rsp_err,
   output logic                          busy,
   output logic [CNT_W-1:0]              op_count
);

   state_e                        state_q, state_d;
   logic                          op_q, op_d;
   logic [1:0]                    io_model_q, io_model_d;
   logic [DATA_W*NUM_CORE-1:0]    wt_data_q, wt_data_d;
   logic [5:0]                    wt_address_q, wt_address_d;
   logic [7:0]                    rd_address_q, rd_address_d;
   logic [RDATA_W*NUM_CORE-1:0]   rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]              op_count_q, op_count_d;
   logic                          pend_q, pend_d;
   logic                          wt_rise, rd_rise, match_rise, hit, timeout, accept;

   dram_done_sync u_wt_sync (.clk(clk), .rst_n(rst_n), .async_in(wt_done), .rise(wt_rise));
   dram_done_sync u_rd_sync (.clk(clk), .rst_n(rst_n), .async_in(rd_done), .rise(rd_rise));

   assign accept     = cmd_valid & cmd_ready;
   assign match_rise = (op_q == OP_RD) ? rd_rise : wt_rise;
   // An edge recognised during ISSUE is parked in pend_q so WAIT_DONE still sees it.
   assign hit        = match_rise | pend_q;

`ifdef DRAM_SEQ_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             rsp_err_q, rsp_err_d;

   assign timeout = (state_q == WAIT_DONE) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
   assign rsp_err = rsp_err_q;

   always_comb begin
      timer_d   = (state_q == WAIT_DONE) ? timer_q + TMR_W'(1) : '0;
      rsp_err_d = rsp_err_q;
      if (state_q == WAIT_DONE) begin
         if (hit)          rsp_err_d = 1'b0;
         else if (timeout) rsp_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         rsp_err_q <= rsp_err_d;
      end
   end
`else
   // TIMEOUT_CYCLES only sizes the abort timer, which this build leaves out.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout            = 1'b0;
   assign rsp_err            = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept) state_d = ISSUE;
         ISSUE:     state_d = WAIT_DONE;
         WAIT_DONE: if (hit || timeout) state_d = RESP;
         RESP:      if (rsp_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      io_en     = (state_q == ISSUE);
      cmd_ready = rst_n && (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      busy      = (state_q != IDLE);
   end

   // NOTE: every always_comb target gets a default first so no latch is inferred.
   always_comb begin
      op_d         = op_q;
      io_model_d   = io_model_q;
      wt_data_d    = wt_data_q;
      wt_address_d = wt_address_q;
      rd_address_d = rd_address_q;
      rsp_data_d   = rsp_data_q;
      op_count_d   = op_count_q;
      pend_d       = pend_q;
      case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            if (accept) begin
               op_d         = cmd_op;
               io_model_d   = model_of(cmd_op);
               wt_data_d    = cmd_wt_data;
               wt_address_d = cmd_wt_addr;
               rd_address_d = cmd_rd_addr;
            end
         end
         ISSUE: pend_d = match_rise;
         WAIT_DONE: begin
            if (hit) begin
               rsp_data_d = (op_q == OP_RD) ? dram_rd_data : '0;
               op_count_d = op_count_q + CNT_W'(1);
               pend_d     = 1'b0;
            end else if (timeout) begin
               rsp_data_d = '0;
               pend_d     = 1'b0;
            end
         end
         RESP: if (rsp_ready) io_model_d = MODEL_IDLE;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q         <= OP_WR;
         io_model_q   <= MODEL_IDLE;
         wt_data_q    <= '0;
         wt_address_q <= '0;
         rd_address_q <= '0;
         rsp_data_q   <= '0;
         op_count_q   <= '0;
         pend_q       <= 1'b0;
      end else begin
         op_q         <= op_d;
         io_model_q   <= io_model_d;
         wt_data_q    <= wt_data_d;
         wt_address_q <= wt_address_d;
         rd_address_q <= rd_address_d;
         rsp_data_q   <= rsp_data_d;
         op_count_q   <= op_count_d;
         pend_q       <= pend_d;
      end
   end

   assign io_model   = io_model_q;
   assign wt_data    = wt_data_q;
   assign wt_address = wt_address_q;
   assign rd_address = rd_address_q;
   assign rsp_op     = op_q;
   assign rsp_data   = rsp_data_q;
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Scoreboard bench for dram_cmd_sequencer: expected completions are queued at command time
// and compared when the sequencer presents its response.
module tb_dram_cmd_sequencer;
   import dram_seq_pkg::*;

   localparam int NC    = 16;
   localparam int TO    = 50;
   localparam int CW    = 16;
   localparam int BOUND = 300;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  cmd_valid = 1'b0;
   logic                  cmd_ready;
   logic                  cmd_op = 1'b0;
   logic [5:0]            cmd_wt_addr = '0;
   logic [7:0]            cmd_rd_addr = '0;
   logic [64*NC-1:0]      cmd_wt_data = '0;
   logic                  io_en;
   logic [1:0]            io_model;
   logic [64*NC-1:0]      wt_data;
   logic [5:0]            wt_address;
   logic [7:0]            rd_address;
   logic                  wt_done = 1'b0;
   logic                  rd_done = 1'b0;
   logic [8*NC-1:0]       dram_rd_data = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b0;
   logic                  rsp_op;
   logic [8*NC-1:0]       rsp_data;
   logic                  rsp_err;
   logic                  busy;
   logic [CW-1:0]         op_count;

   typedef struct {
      logic            op;
      logic [8*NC-1:0] data;
      logic            err;
   } rsp_t;

   rsp_t          sb[$];
   int            n_checks = 0;
   int            n_errors = 0;
   logic [CW-1:0] exp_count = '0;

   dram_cmd_sequencer #(.NUM_CORE(NC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_wt_addr(cmd_wt_addr), .cmd_rd_addr(cmd_rd_addr), .cmd_wt_data(cmd_wt_data),
      .io_en(io_en), .io_model(io_model), .wt_data(wt_data), .wt_address(wt_address),
      .rd_address(rd_address), .wt_done(wt_done), .rd_done(rd_done), .dram_rd_data(dram_rd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic offer_cmd(input logic op, input logic [5:0] wa, input logic [7:0] ra,
                            input logic [63:0] word);
      cmd_op      = op;
      cmd_wt_addr = wa;
      cmd_rd_addr = ra;
      cmd_wt_data = {NC{word}};
      cmd_valid   = 1'b1;
   endtask

   // Called at a negedge with cmd_valid high; returns at the negedge inside ISSUE.
   task automatic accept_cmd();
      int n = 0;
      while (!cmd_ready && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check("accept_bound", 128'(n < BOUND), 128'(1));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_rsp(output int lat);
      int n = 0;
      while (!rsp_valid && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      check("rsp_bound", 128'(rsp_valid), 128'(1));
      lat = n;
   endtask

   task automatic finish_rsp(input int hold);
      rsp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 128'(sb.size()), 128'(1));
         return;
      end
      e = sb.pop_front();
      if (!e.err) exp_count++;
      for (int i = 0; i <= hold; i++) begin
         check("rsp_valid", 128'(rsp_valid), 128'(1));
         check("rsp_op", 128'(rsp_op), 128'(e.op));
         check("rsp_data", 128'(rsp_data), 128'(e.data));
         check("rsp_err", 128'(rsp_err), 128'(e.err));
         check("cmd_ready_busy", 128'(cmd_ready), 128'(0));
         if (i < hold) @(negedge clk);
      end
      check("op_count", 128'(op_count), 128'(exp_count));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("rsp_valid_drop", 128'(rsp_valid), 128'(0));
      check("io_model_idle", 128'(io_model), 128'(MODEL_IDLE));
      check("busy_idle", 128'(busy), 128'(0));
   endtask

   task automatic pulse_done(input logic rd, input int width);
      if (rd) rd_done = 1'b1;
      else    wt_done = 1'b1;
      repeat (width) @(negedge clk);
      rd_done = 1'b0;
      wt_done = 1'b0;
   endtask

   initial begin
      int lat;
      int ones;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 128'(cmd_ready), 128'(0));
      check("rst_io_en", 128'(io_en), 128'(0));
      check("rst_io_model", 128'(io_model), 128'(0));
      check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_op_count", 128'(op_count), 128'(0));
      check("rst_addr", 128'({wt_address, rd_address}), 128'(0));
      check("rst_rsp", 128'({rsp_data, rsp_err}), 128'(0));
      rst_n = 1'b1;
      #1 check("rel_cmd_ready", 128'(cmd_ready), 128'(1));
      @(negedge clk);

      // Write with a single io_en pulse and 3-cycle done-to-response latency
      offer_cmd(OP_WR, 6'h15, 8'h00, 64'hA5A5_0000_FFFF_1234);
      sb.push_back('{op: OP_WR, data: '0, err: 1'b0});
      accept_cmd();
      check("wr_io_en", 128'(io_en), 128'(1));
      check("wr_io_model", 128'(io_model), 128'(MODEL_WR));
      check("wr_address", 128'(wt_address), 128'(6'h15));
      check("wr_data_c1", 128'(wt_data[63:0]), 128'(64'hA5A5_0000_FFFF_1234));
      check("wr_data_c16", 128'(wt_data[64*NC-1 -: 64]), 128'(64'hA5A5_0000_FFFF_1234));
      ones = 0;
      repeat (20) begin
         @(negedge clk);
         if (io_en) ones++;
      end
      check("wr_io_en_single", 128'(ones), 128'(0));
      check("wr_model_hold", 128'(io_model), 128'(MODEL_WR));
      wt_done = 1'b1;
      wait_rsp(lat);
      check("wr_latency", 128'(lat), 128'(3));
      finish_rsp(0);
      wt_done = 1'b0;
      repeat (3) @(negedge clk);

      // Read with per-core data captured on the done edge
      for (int k = 1; k <= NC; k++) dram_rd_data[8*k-1 -: 8] = 8'(k);
      offer_cmd(OP_RD, 6'h00, 8'h9C, 64'h0);
      sb.push_back('{op: OP_RD, data: dram_rd_data, err: 1'b0});
      accept_cmd();
      check("rd_io_model", 128'(io_model), 128'(MODEL_RD));
      check("rd_address", 128'(rd_address), 128'(8'h9C));
      repeat (4) @(negedge clk);
      pulse_done(1'b1, 5);
      wait_rsp(lat);
      dram_rd_data = '1;
      finish_rsp(2);
      repeat (3) @(negedge clk);

      // Write ignores rd_done and completes only on wt_done
      offer_cmd(OP_WR, 6'h2A, 8'h11, 64'h0123_4567_89AB_CDEF);
      sb.push_back('{op: OP_WR, data: '0, err: 1'b0});
      accept_cmd();
      pulse_done(1'b1, 4);
      repeat (6) @(negedge clk);
      check("wrong_done_ignored", 128'(rsp_valid), 128'(0));
      check("wrong_done_busy", 128'(busy), 128'(1));
      wt_done = 1'b1;
      wait_rsp(lat);
      check("wr2_latency", 128'(lat), 128'(3));
      finish_rsp(0);
      wt_done = 1'b0;
      repeat (3) @(negedge clk);

      // Done edge recognised while the sequencer sits in ISSUE
      wt_done = 1'b1;
      @(negedge clk);
      offer_cmd(OP_WR, 6'h01, 8'h00, 64'h5555_AAAA_5555_AAAA);
      sb.push_back('{op: OP_WR, data: '0, err: 1'b0});
      accept_cmd();
      wait_rsp(lat);
      finish_rsp(0);
      wt_done = 1'b0;
      repeat (3) @(negedge clk);

      // Second command back-pressured through WAIT_DONE and a stalled RESP
      offer_cmd(OP_WR, 6'h3F, 8'h00, 64'hFFFF_0000_FFFF_0000);
      sb.push_back('{op: OP_WR, data: '0, err: 1'b0});
      accept_cmd();
      for (int k = 1; k <= NC; k++) dram_rd_data[8*k-1 -: 8] = 8'hF0 ^ 8'(k);
      offer_cmd(OP_RD, 6'h05, 8'h42, 64'h0);
      sb.push_back('{op: OP_RD, data: dram_rd_data, err: 1'b0});
      ones = 0;
      repeat (5) begin
         @(negedge clk);
         if (cmd_ready || io_en) ones++;
      end
      check("bp_wait_ready", 128'(ones), 128'(0));
      wt_done = 1'b1;
      wait_rsp(lat);
      finish_rsp(10);
      wt_done = 1'b0;
      check("bp_ready_after", 128'(cmd_ready), 128'(1));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("bp2_io_en", 128'(io_en), 128'(1));
      check("bp2_io_model", 128'(io_model), 128'(MODEL_RD));
      check("bp2_addr", 128'({wt_address, rd_address}), 128'({6'h05, 8'h42}));
      pulse_done(1'b1, 4);
      wait_rsp(lat);
      finish_rsp(0);
      repeat (3) @(negedge clk);

`ifdef DRAM_SEQ_TIMEOUT_EN
      // Abort after TO cycles in WAIT_DONE; later done edges change nothing
      offer_cmd(OP_WR, 6'h0A, 8'h00, 64'h1);
      sb.push_back('{op: OP_WR, data: '0, err: 1'b1});
      accept_cmd();
      wait_rsp(lat);
      check("to_latency", 128'(lat), 128'(TO + 1));
      wt_done = 1'b1;
      finish_rsp(6);
      wt_done = 1'b0;
      repeat (2) @(negedge clk);
      pulse_done(1'b0, 4);
      ones = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid || busy) ones++;
      end
      check("to_late_ignored", 128'(ones), 128'(0));
      check("to_op_count", 128'(op_count), 128'(exp_count));
`endif

      // Reset in WAIT_DONE clears everything at once and emits no response
      offer_cmd(OP_RD, 6'h07, 8'h77, 64'hDEAD_BEEF_0000_0001);
      accept_cmd();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("ar_cmd_ready", 128'(cmd_ready), 128'(0));
      check("ar_ctrl", 128'({io_en, io_model, rsp_valid, busy, rsp_err}), 128'(0));
      check("ar_addr", 128'({wt_address, rd_address}), 128'(0));
      check("ar_wt_data", 128'(wt_data[63:0]), 128'(0));
      check("ar_rsp_data", 128'(rsp_data), 128'(0));
      check("ar_op_count", 128'(op_count), 128'(0));
      exp_count = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("ar_rel_ready", 128'(cmd_ready), 128'(1));
      pulse_done(1'b1, 4);
      ones = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid || busy) ones++;
      end
      check("ar_no_rsp", 128'(ones), 128'(0));
      check("sb_drain", 128'(sb.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dram_cmd_sequencer.md
Name: dram_cmd_sequencer

Overview:
- Upstream command stage for the 16-core DRAM write/read top.
- Accepts host write/read commands over a valid/ready interface and drives that top's IO_EN, IO_MODEL, WT_DATA1..16, WT_address and RD_address.
- Waits for WT_DONE or RD_DONE, captures DRAM_DATA_OUT1..16 on reads, and returns a completion response over a second valid/ready interface.
- Exactly one DRAM operation is outstanding at a time.

Parameters:
- NUM_CORE, 16, number of DRAM chips; sets the data bus widths.
- TIMEOUT_CYCLES, 4096, clk cycles allowed in WAIT_DONE before abort. Used only with the optional feature.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  1  0 = write, 1 = read.
- cmd_wt_addr  in  6  write row address.
- cmd_rd_addr  in  8  read address.
- cmd_wt_data  in  64*NUM_CORE  write data; core k occupies bits [64k-1:64(k-1)].
- io_en  out  1  to IO_EN.
- io_model  out  2  to IO_MODEL; 01 = write, 10 = read, 00 = idle.
- wt_data  out  64*NUM_CORE  to WT_DATA1..16, same packing as cmd_wt_data.
- wt_address  out  6  to WT_address.
- rd_address  out  8  to RD_address.
- wt_done  in  1  from WT_DONE; asynchronous to clk.
- rd_done  in  1  from RD_DONE; asynchronous to clk.
- dram_rd_data  in  8*NUM_CORE  DRAM_DATA_OUT1..16; core k occupies bits [8k-1:8(k-1)].
- rsp_valid  out  1  completion available.
- rsp_ready  in  1  host consumes the completion.
- rsp_op  out  1  op of the completed command.
- rsp_data  out  8*NUM_CORE  read data; zero for writes.
- rsp_err  out  1  operation timed out.
- busy  out  1  state is not IDLE.
- op_count  out  CNT_W  number of successful completions; wraps.

Behaviour:
- Reset values: all outputs 0, except cmd_ready, which is 1 once reset deasserts. State = IDLE.
- Reset asserted mid-operation aborts the operation immediately; no response is produced.
- wt_done and rd_done each pass through a 2-flop synchroniser, then a rising-edge detector (registered previous value). Edge-to-recognition latency is 3 clk cycles.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch op, both addresses and write data into the output registers; go to ISSUE.
  - The data/address outputs hold these values until the next accept.
- ISSUE (1 cycle):
  - io_en = 1; io_model = 01 (write) or 10 (read).
  - Go to WAIT_DONE.
- WAIT_DONE:
  - io_en = 0; io_model holds its value.
  - Only the edge of the matching done is accepted; the edge of the other done is ignored.
  - A done edge that occurs during ISSUE is still recognised.
  - On the matching edge:
    - Read: capture dram_rd_data into rsp_data the same cycle.
    - Write: rsp_data = 0.
    - Increment op_count (wraps at 2^CNT_W), set rsp_err = 0, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_op, rsp_data and rsp_err are stable while rsp_valid & !rsp_ready.
  - On rsp_ready: io_model = 00, rsp_valid drops next cycle, go to IDLE.
  - The earliest next-command accept is the cycle after rsp_valid falls, so there is no back-to-back overlap.
- cmd_ready = 0 in every state except IDLE. Commands offered while busy are back-pressured, not dropped.
- busy = (state != IDLE).

Optional Feature:
- Macro: DRAM_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_DONE.
  - Reaching TIMEOUT_CYCLES with no matching edge → go to RESP with rsp_err = 1 and rsp_data = 0; op_count does not increment.
  - A done edge arriving after a timeout, while in RESP or IDLE, is ignored.
- Undefined: no counter; WAIT_DONE waits indefinitely; rsp_err is tied to 0.

Decomposition:
- Shared package dram_seq_pkg:
  - State enum IDLE/ISSUE/WAIT_DONE/RESP.
  - IO_MODEL constants MODEL_IDLE = 2'b00, MODEL_WR = 2'b01, MODEL_RD = 2'b10.
  - OP_WR = 0, OP_RD = 1; DATA_W = 64; RDATA_W = 8.
- One sub-module: dram_done_sync (2-flop synchroniser plus rising-edge detector), instantiated twice, once per done input.

Test Plan:
- Write op, addr 6'h15, data all cores 64'hA5A5_0000_FFFF_1234; drive wt_done high 20 cycles after io_en → exactly one io_en pulse with io_model = 01 and wt_address = 0x15; rsp_valid 3 cycles after the edge; rsp_op = 0, rsp_data = 0, op_count = 1.
- Read op, rd_addr 8'h9C; dram_rd_data core k = k; rd_done edge → io_model = 10, rd_address = 0x9C; rsp_data core k = k; rsp_err = 0.
- Write in progress, rd_done pulses first, then wt_done → rd_done ignored; completion occurs only on wt_done.
- Second cmd_valid held during WAIT_DONE and RESP with rsp_ready low for 10 cycles → cmd_ready = 0 throughout, response fields stable, second command accepted only after the RESP handshake.
- DRAM_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES = 50, no done edge → rsp_err = 1 after 50 cycles, op_count unchanged; a late done edge is ignored.
- rst_n dropped during WAIT_DONE → all outputs 0 asynchronously; after release cmd_ready = 1 and no response is emitted.
